branch_predictor_param: RTL and testbench
=========================================

# branch_predictor_param

Parametrised fetch-stage branch predictor: a direct-mapped BTB with 2-bit saturating direction counters, looked up for FETCH_WIDTH consecutive instruction slots per cycle, plus a speculative return address stack with checkpoint restore on misprediction. It sits beside the PC/ICache stage. It takes resolved-branch updates from EX and drives per-lane taken/target predictions and a RAS checkpoint that travels down the pipe with the fetch group.

## Interface
- FETCH_WIDTH, 2, number of lanes per fetch group; lane k address = pc + 4k.
- INDEX_BITS, 8, BTB index width; depth = 2^INDEX_BITS; index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2].
- RAS_DEPTH, 8, RAS entries, power of two; RP = log2(RAS_DEPTH).
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- stall  in  1  fetch group held; no speculative RAS change.
- fetch_valid  in  1  pc carries a real fetch group this cycle.
- pc  in  32  word-aligned address of lane 0.
- upd_valid  in  1  resolved branch from EX this cycle.
- upd_pc  in  32  address of resolved branch.
- upd_type  in  2  00 conditional, 01 direct jump, 10 call, 11 return.
- upd_taken  in  1  actual direction.
- upd_target  in  32  actual target.
- upd_mispredict  in  1  prediction was wrong; restore RAS.
- upd_ras_ptr  in  RP  checkpoint top pointer of the mispredicted group.
- upd_ras_cnt  in  RP+1  checkpoint occupancy of the mispredicted group.
- pred_hit  out  FETCH_WIDTH  per-lane valid tag match.
- pred_taken  out  FETCH_WIDTH  per-lane predicted taken; at most the first taken lane is set.
- pred_target  out  32*FETCH_WIDTH  per-lane target, lane k at [32k+31:32k].
- pred_type  out  2*FETCH_WIDTH  per-lane BTB type.
- ras_ptr_o  out  RP  RAS top pointer before this group's push/pop (checkpoint).
- ras_cnt_o  out  RP+1  RAS occupancy before this group's push/pop.

## Operation
- BTB entry: valid, tag, type, target, ctr[1:0]. Stored in flops and read combinationally.
- Lane lookup: hit = valid & tag match. Predicted taken when: hit & type 00 & ctr[1]; or hit & type 01/10/11.
- Target: the BTB target. Exception: type 11 with ras_cnt > 0 uses the RAS top entry instead.
- Only the lowest taken lane k asserts pred_taken. Higher lanes have pred_taken = 0; their pred_hit, target and type are still driven.
- Speculative RAS action requires fetch_valid & !stall, and applies to the first taken lane only:
  - call: push (lane addr + 8, past the delay slot) at ptr+1 mod RAS_DEPTH; cnt = min(cnt+1, RAS_DEPTH). Overflow overwrites the oldest entry.
  - return with cnt > 0: ptr-1, cnt-1.
  - return with cnt = 0: no change.
- Misprediction restore (upd_valid & upd_mispredict): load ptr/cnt from upd_ras_ptr/upd_ras_cnt, then apply upd_type. Call pushes upd_pc+8; return pops if the restored cnt > 0.
- A restore overrides any same-cycle speculative action.
- BTB update on upd_valid, index/tag from upd_pc:
  - type 00, tag hit: ctr saturating +1 if taken, -1 if not (limits 00/11). Target is rewritten if taken.
  - type 00, miss: if taken, allocate with ctr = 10; if not taken, no write.
  - types 01/10/11: always write valid=1, tag, type, target, ctr = 11.
- Address arithmetic is modulo 2^32. Lane addresses wrap past 0xFFFFFFFC.

## Timing
- Lookup outputs are combinational in pc, BTB and RAS state, valid in the same cycle.
- A BTB update written at edge t is visible to lookups after t. A same-cycle lookup of the updated index sees the old contents.
- RAS push/pop/restore take effect at the edge. ras_ptr_o/ras_cnt_o always show pre-edge state.
- During stall, outputs follow pc with no state change. BTB updates still proceed.
- Reset (asynchronous, at any time, including mid-restore):
  - all BTB valid bits cleared, ctr = 00;
  - RAS ptr = 0, cnt = 0, entries = 0.
  - Hence pred_hit = 0, pred_taken = 0, pred_target = 0, pred_type = 0, ras_ptr_o = 0, ras_cnt_o = 0.

## Test plan
- Reset, then lookup pc=0x80001000 -> pred_hit=0, pred_taken=0, pred_target=0, ras_cnt_o=0.
- Counter training:
  - Step: update cond upd_pc=0x80001004, taken, target 0x80002000; then lookup pc=0x80001000.
  - Expected: lane1 hit, taken, target 0x80002000, lane0 not taken.
  - Step: two not-taken updates -> ctr=00, lane1 hit, pred_taken=0.
- Call/return:
  - Train call at 0x80000100 and return at 0x80003000. Fetch group at 0x80000100 pushes 0x80000108.
  - Then fetch at 0x80003000 -> target 0x80000108, cnt back to 0.
- Overflow: RAS_DEPTH+1 pushes -> cnt saturates at RAS_DEPTH. RAS_DEPTH pops return newest-first; the oldest entry is lost. A further return (cnt=0) uses the BTB target.
- Restore priority:
  - Same cycle: speculative call push and upd_mispredict with upd_ras_ptr=3, upd_ras_cnt=4, upd_type=11.
  - Expected: next cycle ptr=2, cnt=3. The speculative push is discarded.
- Two-lane conflict:
  - Setup: both lanes are trained as jumps.
  - Check: only lane0 pred_taken=1. Only lane0 can push when lane0 is a call and lane1 is a call.
  - Reset asserted mid-stream clears all hits asynchronously.

Source files
------------

// File: rtl/branch_predictor_param.sv
// branch_predictor_param: direct-mapped BTB with 2-bit counters looked up across FETCH_WIDTH lanes,
// plus a speculative return address stack whose pointer/occupancy checkpoint is restored on mispredict.
module branch_predictor_param #(
  parameter int FETCH_WIDTH = 2,
  parameter int INDEX_BITS = 8,
  parameter int RAS_DEPTH = 8,
  localparam int RP = $clog2(RAS_DEPTH)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     stall,
  input  logic                     fetch_valid,
  input  logic [31:0]              pc,
  input  logic                     upd_valid,
  input  logic [31:0]              upd_pc,
  input  logic [1:0]               upd_type,
  input  logic                     upd_taken,
  input  logic [31:0]              upd_target,
  input  logic                     upd_mispredict,
  input  logic [RP-1:0]            upd_ras_ptr,
  input  logic [RP:0]              upd_ras_cnt,
  output logic [FETCH_WIDTH-1:0]   pred_hit,
  output logic [FETCH_WIDTH-1:0]   pred_taken,
  output logic [32*FETCH_WIDTH-1:0] pred_target,
  output logic [2*FETCH_WIDTH-1:0] pred_type,
  output logic [RP-1:0]            ras_ptr_o,
  output logic [RP:0]              ras_cnt_o
);
  localparam int DEPTH = 1 << INDEX_BITS;
  localparam int TW = 30 - INDEX_BITS;
  localparam logic [RP:0] RAS_FULL = (RP+1)'(RAS_DEPTH);

  logic            btb_v_q   [DEPTH];
  logic [TW-1:0]   btb_tag_q [DEPTH];
  logic [1:0]      btb_ty_q  [DEPTH];
  logic [31:0]     btb_tgt_q [DEPTH];
  logic [1:0]      btb_ctr_q [DEPTH];
  logic [31:0]     ras_q     [RAS_DEPTH];
  logic [RP-1:0]   ptr_q, ptr_d, base_ptr;
  logic [RP:0]     cnt_q, cnt_d, base_cnt;
  logic [31:0]     lane_addr, first_addr, op_addr;
  logic [INDEX_BITS-1:0] li, uidx;
  logic [1:0]      first_ty, op_ty, ctr_d;
  logic            lane_tk, found, restore, op_en, push, pop, uhit;

  // Lanes are scanned low to high so only the first taken lane predicts taken and drives the RAS.
  always_comb begin
    found = 1'b0;
    first_ty = '0;
    first_addr = '0;
    lane_addr = '0;
    li = '0;
    lane_tk = 1'b0;
    pred_hit = '0;
    pred_taken = '0;
    pred_target = '0;
    pred_type = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      lane_addr = pc + 32'(4 * k);
      li = lane_addr[INDEX_BITS+1:2];
      pred_hit[k] = btb_v_q[li] && btb_tag_q[li] == lane_addr[31:INDEX_BITS+2];
      lane_tk = pred_hit[k] && (btb_ty_q[li] != 2'b00 || btb_ctr_q[li][1]);
      pred_type[2*k +: 2] = btb_ty_q[li];
      pred_target[32*k +: 32] = (btb_ty_q[li] == 2'b11 && cnt_q != '0) ? ras_q[ptr_q] : btb_tgt_q[li];
      pred_taken[k] = lane_tk && !found;
      if (lane_tk && !found) begin
        first_ty = btb_ty_q[li];
        first_addr = lane_addr;
      end
      found = found | lane_tk;
    end
  end

  // A restore replaces the speculative action: reload the checkpoint, then replay the resolved branch.
  always_comb begin
    restore = upd_valid && upd_mispredict;
    op_en = restore || (fetch_valid && !stall && found);
    base_ptr = restore ? upd_ras_ptr : ptr_q;
    base_cnt = restore ? upd_ras_cnt : cnt_q;
    op_ty = restore ? upd_type : first_ty;
    op_addr = (restore ? upd_pc : first_addr) + 32'd8;
    push = op_en && op_ty == 2'b10;
    pop = op_en && op_ty == 2'b11 && base_cnt != '0;
    ptr_d = push ? base_ptr + RP'(1) : pop ? base_ptr - RP'(1) : base_ptr;
    cnt_d = push ? (base_cnt == RAS_FULL ? base_cnt : base_cnt + (RP+1)'(1)) :
            pop  ? base_cnt - (RP+1)'(1) : base_cnt;
  end

  always_comb begin
    uidx = upd_pc[INDEX_BITS+1:2];
    uhit = btb_v_q[uidx] && btb_tag_q[uidx] == upd_pc[31:INDEX_BITS+2];
    ctr_d = upd_taken ? (btb_ctr_q[uidx] == 2'b11 ? 2'b11 : btb_ctr_q[uidx] + 2'b01) :
                        (btb_ctr_q[uidx] == 2'b00 ? 2'b00 : btb_ctr_q[uidx] - 2'b01);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        btb_v_q[i] <= 1'b0;
        btb_tag_q[i] <= '0;
        btb_ty_q[i] <= '0;
        btb_tgt_q[i] <= '0;
        btb_ctr_q[i] <= '0;
      end
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (push) ras_q[ptr_d] <= op_addr;
      if (upd_valid) begin
        if (upd_type != 2'b00) begin
          btb_v_q[uidx] <= 1'b1;
          btb_tag_q[uidx] <= upd_pc[31:INDEX_BITS+2];
          btb_ty_q[uidx] <= upd_type;
          btb_tgt_q[uidx] <= upd_target;
          btb_ctr_q[uidx] <= 2'b11;
        end else if (uhit) begin
          btb_ctr_q[uidx] <= ctr_d;
          if (upd_taken) btb_tgt_q[uidx] <= upd_target;
        end else if (upd_taken) begin
          btb_v_q[uidx] <= 1'b1;
          btb_tag_q[uidx] <= upd_pc[31:INDEX_BITS+2];
          btb_ty_q[uidx] <= 2'b00;
          btb_tgt_q[uidx] <= upd_target;
          btb_ctr_q[uidx] <= 2'b10;
        end
      end
    end
  end

  assign ras_ptr_o = ptr_q;
  assign ras_cnt_o = cnt_q;
endmodule

// File: tb/tb_branch_predictor_param.sv
// tb_branch_predictor_param: directed scenarios plus randomized traffic checked against a behavioural predictor model.
module tb_branch_predictor_param;
  localparam int FW = 2;
  localparam int RD = 8;
  localparam int RP = 3;

  logic clk, resetn, stall, fetch_valid, upd_valid, upd_taken, upd_mispredict;
  logic [31:0] pc, upd_pc, upd_target;
  logic [1:0] upd_type;
  logic [RP-1:0] upd_ras_ptr, ras_ptr_o;
  logic [RP:0] upd_ras_cnt, ras_cnt_o;
  logic [FW-1:0] pred_hit, pred_taken;
  logic [32*FW-1:0] pred_target;
  logic [2*FW-1:0] pred_type;
  int n_checks = 0;
  int n_fail = 0;

  bit m_v [256];
  logic [21:0] m_tag [256];
  int m_ty [256];
  logic [31:0] m_tgt [256];
  int m_ctr [256];
  logic [31:0] m_ras [RD];
  int m_ptr, m_cnt;
  logic [FW-1:0] e_hit, e_tk;
  logic [32*FW-1:0] e_tgt;
  logic [2*FW-1:0] e_ty;
  int e_first, e_fty;
  logic [31:0] e_faddr;

  branch_predictor_param #(.FETCH_WIDTH(FW), .INDEX_BITS(8), .RAS_DEPTH(RD)) dut (
    .clk(clk), .resetn(resetn), .stall(stall), .fetch_valid(fetch_valid), .pc(pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_type(upd_type), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict), .upd_ras_ptr(upd_ras_ptr),
    .upd_ras_cnt(upd_ras_cnt), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_type(pred_type), .ras_ptr_o(ras_ptr_o), .ras_cnt_o(ras_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_v[i] = 0; m_tag[i] = '0; m_ty[i] = 0; m_tgt[i] = '0; m_ctr[i] = 0;
    end
    for (int i = 0; i < RD; i++) m_ras[i] = '0;
    m_ptr = 0;
    m_cnt = 0;
  endtask

  task automatic model_predict();
    logic [31:0] a;
    int i;
    e_hit = '0; e_tk = '0; e_tgt = '0; e_ty = '0; e_first = -1; e_fty = 0; e_faddr = '0;
    for (int k = 0; k < FW; k++) begin
      a = pc + 32'(4 * k);
      i = int'(a[9:2]);
      e_hit[k] = m_v[i] && m_tag[i] == a[31:10];
      e_ty[2*k +: 2] = 2'(m_ty[i]);
      e_tgt[32*k +: 32] = (m_ty[i] == 3 && m_cnt > 0) ? m_ras[m_ptr] : m_tgt[i];
      if (e_hit[k] && (m_ty[i] != 0 || m_ctr[i] >= 2) && e_first < 0) begin
        e_first = k; e_tk[k] = 1'b1; e_faddr = a; e_fty = m_ty[i];
      end
    end
  endtask

  task automatic model_edge();
    int i, pt;
    logic [31:0] pa;
    bit act;
    act = 0; pt = 0; pa = '0;
    if (upd_valid && upd_mispredict) begin
      m_ptr = int'(upd_ras_ptr); m_cnt = int'(upd_ras_cnt); pt = int'(upd_type); pa = upd_pc + 8; act = 1;
    end else if (fetch_valid && !stall && e_first >= 0) begin
      pt = e_fty; pa = e_faddr + 8; act = 1;
    end
    if (act && pt == 2) begin
      m_ptr = (m_ptr + 1) % RD; m_ras[m_ptr] = pa; if (m_cnt < RD) m_cnt++;
    end else if (act && pt == 3 && m_cnt > 0) begin
      m_ptr = (m_ptr + RD - 1) % RD; m_cnt--;
    end
    if (upd_valid) begin
      i = int'(upd_pc[9:2]);
      if (upd_type != 0) begin
        m_v[i] = 1; m_tag[i] = upd_pc[31:10]; m_ty[i] = int'(upd_type); m_tgt[i] = upd_target; m_ctr[i] = 3;
      end else if (m_v[i] && m_tag[i] == upd_pc[31:10]) begin
        m_ctr[i] = upd_taken ? (m_ctr[i] < 3 ? m_ctr[i] + 1 : 3) : (m_ctr[i] > 0 ? m_ctr[i] - 1 : 0);
        if (upd_taken) m_tgt[i] = upd_target;
      end else if (upd_taken) begin
        m_v[i] = 1; m_tag[i] = upd_pc[31:10]; m_ty[i] = 0; m_tgt[i] = upd_target; m_ctr[i] = 2;
      end
    end
  endtask

  task automatic step();
    model_predict();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    fetch_valid = 0; stall = 0; pc = '0; upd_valid = 0; upd_pc = '0; upd_type = '0; upd_taken = 0;
    upd_target = '0; upd_mispredict = 0; upd_ras_ptr = '0; upd_ras_cnt = '0;
  endtask

  task automatic train(input logic [31:0] a, input logic [1:0] ty, input logic tk, input logic [31:0] tg);
    idle();
    upd_valid = 1; upd_pc = a; upd_type = ty; upd_taken = tk; upd_target = tg;
    step();
    idle();
  endtask

  task automatic fetch(input logic [31:0] a);
    idle();
    fetch_valid = 1; pc = a;
    #1;
  endtask

  task automatic test_reset();
    fetch(32'h8000_1000);
    n_checks++; if (pred_hit !== 2'b00) begin n_fail++; $display("FAIL reset_hit: got %b want 00", pred_hit); end
    n_checks++; if (pred_taken !== 2'b00) begin n_fail++; $display("FAIL reset_taken: got %b want 00", pred_taken); end
    n_checks++; if (pred_target !== 64'h0) begin n_fail++; $display("FAIL reset_target: got %h want 0", pred_target); end
    n_checks++; if (pred_type !== 4'h0) begin n_fail++; $display("FAIL reset_type: got %h want 0", pred_type); end
    n_checks++; if (ras_cnt_o !== 4'd0 || ras_ptr_o !== 3'd0) begin n_fail++; $display("FAIL reset_ras: got ptr %0d cnt %0d want 0 0", ras_ptr_o, ras_cnt_o); end
    step();
  endtask

  task automatic test_counter();
    fetch(32'h8000_1000);
    upd_valid = 1; upd_pc = 32'h8000_1004; upd_type = 2'b00; upd_taken = 1; upd_target = 32'h8000_2000;
    #1;
    n_checks++; if (pred_hit !== 2'b00) begin n_fail++; $display("FAIL same_cycle_old: got %b want 00", pred_hit); end
    step();
    fetch(32'h8000_1000);
    n_checks++; if (pred_hit !== 2'b10 || pred_taken !== 2'b10) begin n_fail++; $display("FAIL ctr_alloc: hit %b taken %b want 10 10", pred_hit, pred_taken); end
    n_checks++; if (pred_target[63:32] !== 32'h8000_2000) begin n_fail++; $display("FAIL ctr_target: got %h want 80002000", pred_target[63:32]); end
    step();
    train(32'h8000_1004, 2'b00, 0, 32'h8000_9990);
    fetch(32'h8000_1000);
    n_checks++; if (pred_hit !== 2'b10 || pred_taken !== 2'b00 || pred_target[63:32] !== 32'h8000_2000) begin
      n_fail++; $display("FAIL ctr_01: hit %b taken %b tgt %h want 10 00 80002000", pred_hit, pred_taken, pred_target[63:32]); end
    step();
    train(32'h8000_1004, 2'b00, 0, 32'h8000_9990);
    train(32'h8000_1004, 2'b00, 0, 32'h8000_9990);
    train(32'h8000_1004, 2'b00, 1, 32'h8000_2000);
    fetch(32'h8000_1000);
    n_checks++; if (pred_hit !== 2'b10 || pred_taken !== 2'b00) begin n_fail++; $display("FAIL ctr_sat_low: hit %b taken %b want 10 00", pred_hit, pred_taken); end
    step();
    train(32'h8000_1004, 2'b00, 1, 32'h8000_2000);
    fetch(32'h8000_1000);
    n_checks++; if (pred_taken !== 2'b10) begin n_fail++; $display("FAIL ctr_retrain: taken %b want 10", pred_taken); end
    step();
  endtask

  task automatic test_call_return();
    train(32'h8000_0100, 2'b10, 1, 32'h8000_4000);
    train(32'h8000_3000, 2'b11, 1, 32'h8000_5000);
    fetch(32'h8000_0100);
    n_checks++; if (pred_taken !== 2'b01 || pred_target[31:0] !== 32'h8000_4000 || ras_cnt_o !== 4'd0) begin
      n_fail++; $display("FAIL call_fetch: taken %b tgt %h cnt %0d want 01 80004000 0", pred_taken, pred_target[31:0], ras_cnt_o); end
    step();
    fetch(32'h8000_3000);
    n_checks++; if (pred_target[31:0] !== 32'h8000_0108 || ras_cnt_o !== 4'd1) begin
      n_fail++; $display("FAIL ret_fetch: tgt %h cnt %0d want 80000108 1", pred_target[31:0], ras_cnt_o); end
    step();
    idle(); #1;
    n_checks++; if (ras_cnt_o !== 4'd0) begin n_fail++; $display("FAIL ret_pop: cnt %0d want 0", ras_cnt_o); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i <= RD; i++) train(32'h8001_0040 + 32'(8 * i), 2'b10, 1, 32'h8000_6000);
    for (int i = 0; i <= RD; i++) begin fetch(32'h8001_0040 + 32'(8 * i)); step(); end
    idle(); #1;
    n_checks++; if (ras_cnt_o !== 4'd8) begin n_fail++; $display("FAIL ovf_cnt: got %0d want 8", ras_cnt_o); end
    for (int j = RD; j >= 1; j--) begin
      fetch(32'h8000_3000);
      n_checks++; if (pred_target[31:0] !== 32'h8001_0048 + 32'(8 * j) || ras_cnt_o !== 4'(j)) begin
        n_fail++; $display("FAIL ovf_pop%0d: tgt %h cnt %0d want %h %0d", j, pred_target[31:0], ras_cnt_o, 32'h8001_0048 + 32'(8 * j), j); end
      step();
    end
    fetch(32'h8000_3000);
    n_checks++; if (pred_target[31:0] !== 32'h8000_5000 || pred_taken !== 2'b01 || ras_cnt_o !== 4'd0) begin
      n_fail++; $display("FAIL empty_ret: tgt %h taken %b cnt %0d want 80005000 01 0", pred_target[31:0], pred_taken, ras_cnt_o); end
    step();
    idle(); #1;
    n_checks++; if (ras_cnt_o !== 4'd0) begin n_fail++; $display("FAIL empty_ret_cnt: got %0d want 0", ras_cnt_o); end
  endtask

  task automatic test_restore();
    fetch(32'h8000_0100);
    upd_valid = 1; upd_mispredict = 1; upd_type = 2'b11; upd_pc = 32'h8000_3000; upd_taken = 1;
    upd_target = 32'h8000_5000; upd_ras_ptr = 3'd3; upd_ras_cnt = 4'd4;
    step();
    idle(); #1;
    n_checks++; if (ras_ptr_o !== 3'd2 || ras_cnt_o !== 4'd3) begin n_fail++; $display("FAIL restore_ret: ptr %0d cnt %0d want 2 3", ras_ptr_o, ras_cnt_o); end
    fetch(32'h8000_3000);
    upd_valid = 1; upd_mispredict = 1; upd_type = 2'b10; upd_pc = 32'h8000_0100; upd_taken = 1;
    upd_target = 32'h8000_4000; upd_ras_ptr = 3'd5; upd_ras_cnt = 4'd8;
    step();
    fetch(32'h8000_3000);
    n_checks++; if (ras_ptr_o !== 3'd6 || ras_cnt_o !== 4'd8 || pred_target[31:0] !== 32'h8000_0108) begin
      n_fail++; $display("FAIL restore_call: ptr %0d cnt %0d tgt %h want 6 8 80000108", ras_ptr_o, ras_cnt_o, pred_target[31:0]); end
    step();
  endtask

  task automatic test_two_lane();
    int c;
    train(32'h8002_0200, 2'b01, 1, 32'h8003_0000);
    train(32'h8002_0204, 2'b01, 1, 32'h8003_1000);
    fetch(32'h8002_0200);
    n_checks++; if (pred_hit !== 2'b11 || pred_taken !== 2'b01 || pred_type !== 4'b0101) begin
      n_fail++; $display("FAIL two_jump: hit %b taken %b type %b want 11 01 0101", pred_hit, pred_taken, pred_type); end
    n_checks++; if (pred_target !== {32'h8003_1000, 32'h8003_0000}) begin n_fail++; $display("FAIL two_jump_tgt: got %h", pred_target); end
    step();
    train(32'h8002_0200, 2'b10, 1, 32'h8003_0000);
    train(32'h8002_0204, 2'b10, 1, 32'h8003_1000);
    fetch(32'h8002_0200);
    c = m_cnt;
    n_checks++; if (pred_taken !== 2'b01 || pred_type !== 4'b1010) begin n_fail++; $display("FAIL two_call: taken %b type %b want 01 1010", pred_taken, pred_type); end
    step();
    fetch(32'h8000_3000);
    n_checks++; if (pred_target[31:0] !== 32'h8002_0208 || int'(ras_cnt_o) !== (c < RD ? c + 1 : RD)) begin
      n_fail++; $display("FAIL two_call_push: tgt %h cnt %0d want 80020208 %0d", pred_target[31:0], ras_cnt_o, c < RD ? c + 1 : RD); end
    step();
    fetch(32'h8002_0200);
    stall = 1;
    c = m_cnt;
    step();
    idle(); #1;
    n_checks++; if (int'(ras_cnt_o) !== c) begin n_fail++; $display("FAIL stall_hold: cnt %0d want %0d", ras_cnt_o, c); end
  endtask

  task automatic test_async_reset();
    fetch(32'h8002_0200);
    #2;
    resetn = 0;
    #1;
    n_checks++; if (pred_hit !== 2'b00 || pred_taken !== 2'b00 || pred_target !== 64'h0) begin
      n_fail++; $display("FAIL async_reset: hit %b taken %b tgt %h want 00 00 0", pred_hit, pred_taken, pred_target); end
    n_checks++; if (ras_cnt_o !== 4'd0 || ras_ptr_o !== 3'd0) begin n_fail++; $display("FAIL async_reset_ras: ptr %0d cnt %0d want 0 0", ras_ptr_o, ras_cnt_o); end
    model_reset();
    @(negedge clk);
    resetn = 1;
    idle();
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 400; n++) begin
      idle();
      a = ($urandom_range(0, 1) != 0 ? 32'h9004_0000 : 32'h8004_0000) + 32'(4 * $urandom_range(0, 31));
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : a;
      fetch_valid = $urandom_range(0, 3) != 0;
      stall = $urandom_range(0, 3) == 0;
      upd_valid = $urandom_range(0, 1) != 0;
      a = ($urandom_range(0, 1) != 0 ? 32'h9004_0000 : 32'h8004_0000) + 32'(4 * $urandom_range(0, 31));
      upd_pc = ($urandom_range(0, 15) == 0) ? 32'h0 : a;
      upd_type = 2'($urandom_range(0, 3));
      upd_taken = $urandom_range(0, 1) != 0;
      upd_target = $urandom & 32'hFFFF_FFFC;
      upd_mispredict = $urandom_range(0, 7) == 0;
      upd_ras_ptr = 3'($urandom_range(0, 7));
      upd_ras_cnt = 4'($urandom_range(0, 8));
      #1;
      model_predict();
      n_checks++; if (pred_hit !== e_hit || pred_taken !== e_tk) begin
        n_fail++; $display("FAIL rnd_dir[%0d]: hit %b taken %b want %b %b", n, pred_hit, pred_taken, e_hit, e_tk); end
      n_checks++; if (pred_target !== e_tgt || pred_type !== e_ty) begin
        n_fail++; $display("FAIL rnd_tgt[%0d]: tgt %h type %b want %h %b", n, pred_target, pred_type, e_tgt, e_ty); end
      n_checks++; if (int'(ras_ptr_o) !== m_ptr || int'(ras_cnt_o) !== m_cnt) begin
        n_fail++; $display("FAIL rnd_ras[%0d]: ptr %0d cnt %0d want %0d %0d", n, ras_ptr_o, ras_cnt_o, m_ptr, m_cnt); end
      step();
    end
  endtask

  initial begin
    idle();
    resetn = 0;
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1;
    test_reset();
    test_counter();
    test_call_return();
    test_overflow();
    test_restore();
    test_two_lane();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
